// File: rtl/mips_mem_responder.sv
// mips_mem_responder
// Memory-side responder for the MIPS core. It holds an instruction bank that
// the core can only read, and a data bank that the core can read and write.
// Both banks are word-organised and byte-addressed. A preload port lets a
// loader fill either bank. The block also keeps sticky error flags and a
// saturating count of committed core stores.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_i_addr / o_i_inst   instruction fetch address / registered instruction
//   i_d_wen, i_d_addr,    core store enable, data byte address, store data
//   i_d_wdata
//   o_d_rdata             registered load data (read-before-write)
//   i_ld_en, i_ld_sel,    preload strobe, target bank (0 = instr, 1 = data),
//   i_ld_addr, i_ld_data  preload byte address and word
//   o_err_align           sticky: misaligned core fetch/load/store address
//   o_err_range           sticky: out-of-range core fetch/load/store address
//   o_err_conflict        sticky: core store dropped because a preload hit
//                         the same data word in the same cycle
//   o_wr_cnt              saturating count of committed core stores
module mips_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int I_DEPTH = 64,
    parameter int D_DEPTH = 64,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_i_addr,
    output logic [DATA_W-1:0] o_i_inst,
    input  logic              i_d_wen,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    input  logic              i_ld_en,
    input  logic              i_ld_sel,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_err_align,
    output logic              o_err_range,
    output logic              o_err_conflict,
    output logic [CNT_W-1:0]  o_wr_cnt
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int I_AW  = $clog2(I_DEPTH);
    localparam int D_AW  = $clog2(D_DEPTH);

    logic [DATA_W-1:0] ibank [I_DEPTH];
    logic [DATA_W-1:0] dbank [D_DEPTH];

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic [IDX_W-1:0] ld_idx;

    logic f_align_ok;
    logic f_range_ok;
    logic d_align_ok;
    logic d_range_ok;
    logic ld_align_ok;
    logic ld_i_we;
    logic ld_d_we;
    logic st_ok;
    logic collide;
    logic st_commit;

    assign f_idx  = i_i_addr[ADDR_W-1:2];
    assign d_idx  = i_d_addr[ADDR_W-1:2];
    assign ld_idx = i_ld_addr[ADDR_W-1:2];

    assign f_align_ok  = (i_i_addr[1:0] == 2'b00);
    assign d_align_ok  = (i_d_addr[1:0] == 2'b00);
    assign ld_align_ok = (i_ld_addr[1:0] == 2'b00);
    assign f_range_ok  = (f_idx < IDX_W'(I_DEPTH));
    assign d_range_ok  = (d_idx < IDX_W'(D_DEPTH));

    // Bad preloads are simply dropped; they never raise a flag.
    assign ld_i_we = i_ld_en && !i_ld_sel && ld_align_ok && (ld_idx < IDX_W'(I_DEPTH));
    assign ld_d_we = i_ld_en &&  i_ld_sel && ld_align_ok && (ld_idx < IDX_W'(D_DEPTH));

    // A legal store loses to a preload of the same data word.
    assign st_ok     = i_d_wen && d_align_ok && d_range_ok;
    assign collide   = ld_d_we && (ld_idx == d_idx);
    assign st_commit = st_ok && !collide;

    // Instruction bank: written only by the preload port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < I_DEPTH; k++) begin
                ibank[k] <= '0;
            end
        end else if (ld_i_we) begin
            ibank[ld_idx[I_AW-1:0]] <= i_ld_data;
        end
    end

    // Data bank: a preload and a committed store never target the same word
    // in one cycle, because a collision suppresses the store.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < D_DEPTH; k++) begin
                dbank[k] <= '0;
            end
        end else begin
            if (ld_d_we) begin
                dbank[ld_idx[D_AW-1:0]] <= i_ld_data;
            end
            if (st_commit) begin
                dbank[d_idx[D_AW-1:0]] <= i_d_wdata;
            end
        end
    end

    // Registered read ports sample the banks before this edge's writes land,
    // which yields read-before-write behaviour. Bad addresses return zero,
    // the core's end marker.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_i_inst  <= '0;
            o_d_rdata <= '0;
        end else begin
            o_i_inst  <= (f_align_ok && f_range_ok) ? ibank[f_idx[I_AW-1:0]] : '0;
            o_d_rdata <= (d_align_ok && d_range_ok) ? dbank[d_idx[D_AW-1:0]] : '0;
        end
    end

    // Sticky flags and the saturating store counter. Fetch and data addresses
    // are checked every cycle, so a bad store also trips the flags through
    // its read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_align    <= 1'b0;
            o_err_range    <= 1'b0;
            o_err_conflict <= 1'b0;
            o_wr_cnt       <= '0;
        end else begin
            if (!f_align_ok || !d_align_ok) begin
                o_err_align <= 1'b1;
            end
            if (!f_range_ok || !d_range_ok) begin
                o_err_range <= 1'b1;
            end
            if (st_ok && collide) begin
                o_err_conflict <= 1'b1;
            end
            if (st_commit && (o_wr_cnt != {CNT_W{1'b1}})) begin
                o_wr_cnt <= o_wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder
// Directed bench for mips_mem_responder (CNT_W reduced to 4 so saturation is
// reachable). A table of single-cycle vectors walks through fetch, load,
// store, alignment/range errors and collisions; hand-written sequences cover
// counter saturation, asynchronous reset and fetch-side errors.
module tb_mips_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_addr;
    logic [31:0] inst;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        ld_en;
    logic        ld_sel;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        err_align;
    logic        err_range;
    logic        err_conflict;
    logic [3:0]  wr_cnt;

    int total = 0;
    int bad   = 0;

    mips_mem_responder #(
        .ADDR_W (32),
        .DATA_W (32),
        .I_DEPTH(64),
        .D_DEPTH(64),
        .CNT_W  (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_i_addr      (i_addr),
        .o_i_inst      (inst),
        .i_d_wen       (d_wen),
        .i_d_addr      (d_addr),
        .i_d_wdata     (d_wdata),
        .o_d_rdata     (d_rdata),
        .i_ld_en       (ld_en),
        .i_ld_sel      (ld_sel),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data),
        .o_err_align   (err_align),
        .o_err_range   (err_range),
        .o_err_conflict(err_conflict),
        .o_wr_cnt      (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i_addr;
        logic        d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        ld_en;
        logic        ld_sel;
        logic [31:0] ld_addr;
        logic [31:0] ld_data;
        logic [31:0] e_inst;
        logic [31:0] e_rdata;
        logic        e_align;
        logic        e_range;
        logic        e_conf;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [31:0] ia, input logic wen, input logic [31:0] da,
        input logic [31:0] wd, input logic le, input logic ls,
        input logic [31:0] la, input logic [31:0] ldd,
        input logic [31:0] ei, input logic [31:0] er, input logic ea,
        input logic ern, input logic ec, input logic [3:0] en);
        vec_t v;
        v.i_addr = ia;  v.d_wen = wen; v.d_addr = da;  v.d_wdata = wd;
        v.ld_en  = le;  v.ld_sel = ls; v.ld_addr = la; v.ld_data = ldd;
        v.e_inst = ei;  v.e_rdata = er; v.e_align = ea; v.e_range = ern;
        v.e_conf = ec;  v.e_cnt = en;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ia, input logic wen,
                                 input logic [31:0] da, input logic [31:0] wd,
                                 input logic le, input logic ls,
                                 input logic [31:0] la, input logic [31:0] ldd);
        i_addr = ia; d_wen = wen; d_addr = da; d_wdata = wd;
        ld_en = le;  ld_sel = ls; ld_addr = la; ld_data = ldd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] ei,
                            input logic [31:0] er, input logic ea,
                            input logic ern, input logic ec, input logic [3:0] en);
        checkOutput({tag, ".inst"},     inst,                 ei);
        checkOutput({tag, ".rdata"},    d_rdata,              er);
        checkOutput({tag, ".align"},    {31'b0, err_align},   {31'b0, ea});
        checkOutput({tag, ".range"},    {31'b0, err_range},   {31'b0, ern});
        checkOutput({tag, ".conflict"}, {31'b0, err_conflict},{31'b0, ec});
        checkOutput({tag, ".cnt"},      {28'b0, wr_cnt},      {28'b0, en});
    endtask

    initial begin
        // i_addr, wen, d_addr, wdata, ld_en, ld_sel, ld_addr, ld_data,
        // exp inst, exp rdata, align, range, conflict, cnt
        vecs.push_back(mk(32'h0, 0, 32'h00, 32'h0,      1, 0, 32'h000, 32'h00221820, 32'h0,        32'h0,        0, 0, 0, 4'd0));
        vecs.push_back(mk(32'h0, 0, 32'h00, 32'h0,      1, 0, 32'h004, 32'h20210004, 32'h00221820, 32'h0,        0, 0, 0, 4'd0));
        vecs.push_back(mk(32'h4, 0, 32'h00, 32'h0,      1, 0, 32'h008, 32'h00000000, 32'h20210004, 32'h0,        0, 0, 0, 4'd0));
        vecs.push_back(mk(32'h8, 0, 32'h00, 32'h0,      0, 0, 32'h000, 32'h0,        32'h0,        32'h0,        0, 0, 0, 4'd0));
        vecs.push_back(mk(32'h0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h000, 32'h0,      32'h00221820, 32'h0,        0, 0, 0, 4'd1));
        vecs.push_back(mk(32'h4, 0, 32'h10, 32'h0,      0, 0, 32'h000, 32'h0,        32'h20210004, 32'hDEADBEEF, 0, 0, 0, 4'd1));
        vecs.push_back(mk(32'h4, 1, 32'h12, 32'h12345678, 0, 0, 32'h000, 32'h0,      32'h20210004, 32'h0,        1, 0, 0, 4'd1));
        vecs.push_back(mk(32'h4, 0, 32'h10, 32'h0,      0, 0, 32'h000, 32'h0,        32'h20210004, 32'hDEADBEEF, 1, 0, 0, 4'd1));
        vecs.push_back(mk(32'h4, 1, 32'h400, 32'hCAFEF00D, 0, 0, 32'h000, 32'h0,     32'h20210004, 32'h0,        1, 1, 0, 4'd1));
        vecs.push_back(mk(32'h4, 0, 32'h10, 32'h0,      0, 0, 32'h000, 32'h0,        32'h20210004, 32'hDEADBEEF, 1, 1, 0, 4'd1));
        vecs.push_back(mk(32'h4, 1, 32'h20, 32'h22222222, 1, 1, 32'h020, 32'h11111111, 32'h20210004, 32'h0,      1, 1, 1, 4'd1));
        vecs.push_back(mk(32'h4, 0, 32'h20, 32'h0,      0, 0, 32'h000, 32'h0,        32'h20210004, 32'h11111111, 1, 1, 1, 4'd1));
        vecs.push_back(mk(32'h4, 0, 32'h20, 32'h0,      1, 1, 32'h022, 32'h33333333, 32'h20210004, 32'h11111111, 1, 1, 1, 4'd1));
        vecs.push_back(mk(32'h0, 0, 32'h20, 32'h0,      1, 0, 32'h100, 32'h44444444, 32'h00221820, 32'h11111111, 1, 1, 1, 4'd1));
        vecs.push_back(mk(32'h0, 1, 32'h24, 32'h55555555, 1, 1, 32'h028, 32'h66666666, 32'h00221820, 32'h0,      1, 1, 1, 4'd2));
        vecs.push_back(mk(32'h0, 0, 32'h24, 32'h0,      0, 0, 32'h000, 32'h0,        32'h00221820, 32'h55555555, 1, 1, 1, 4'd2));
        vecs.push_back(mk(32'h0, 0, 32'h28, 32'h0,      0, 0, 32'h000, 32'h0,        32'h00221820, 32'h66666666, 1, 1, 1, 4'd2));
        vecs.push_back(mk(32'h0, 0, 32'h00, 32'h0,      0, 0, 32'h000, 32'h0,        32'h00221820, 32'h0,        1, 1, 1, 4'd2));

        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();
        checkAll("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].i_addr, vecs[n].d_wen, vecs[n].d_addr, vecs[n].d_wdata,
                          vecs[n].ld_en, vecs[n].ld_sel, vecs[n].ld_addr, vecs[n].ld_data);
            tick();
            checkAll($sformatf("vec%0d", n), vecs[n].e_inst, vecs[n].e_rdata,
                     vecs[n].e_align, vecs[n].e_range, vecs[n].e_conf, vecs[n].e_cnt);
        end

        // Twenty legal stores starting from a count of 2: the counter must
        // climb to 15 and stay there.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(32'h0, 1'b1, 32'h30 + 32'(4 * k), 32'(k + 1),
                          1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            checkOutput($sformatf("sat%0d.cnt", k), {28'b0, wr_cnt},
                        (k + 3 > 15) ? 32'd15 : 32'(k + 3));
        end

        // Asynchronous reset between edges.
        applyStimulus(32'h0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkAll("prerst", 32'h00221820, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 4'd15);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("asyncrst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        #3;
        rst_n = 1'b1;
        tick();
        checkAll("postrst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Fetch-side errors: out-of-range alone, then misaligned.
        applyStimulus(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkAll("frange", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        applyStimulus(32'h6, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkAll("falign", 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the MIPS core's instruction-fetch and data-access ports.
- Holds a read-only-to-core instruction bank and a read/write data bank, both word-organised and byte-addressed.
- Returns registered read data and applies core stores.
- Provides a preload port for the bench/loader, sticky error flags, and a store counter.

Parameters:
ADDR_W, 32, byte-address width of all address ports
DATA_W, 32, word width (instruction and data)
I_DEPTH, 64, instruction bank depth in words (power of 2)
D_DEPTH, 64, data bank depth in words (power of 2)
CNT_W, 16, store-counter width

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_i_addr  input  ADDR_W  instruction fetch byte address from core
o_i_inst  output  DATA_W  fetched instruction, registered
i_d_wen  input  1  core store enable
i_d_addr  input  ADDR_W  core data byte address
i_d_wdata  input  DATA_W  core store data
o_d_rdata  output  DATA_W  load data, registered
i_ld_en  input  1  preload write strobe
i_ld_sel  input  1  preload target: 0 = instruction bank, 1 = data bank
i_ld_addr  input  ADDR_W  preload byte address
i_ld_data  input  DATA_W  preload word
o_err_align  output  1  sticky flag: misaligned core access
o_err_range  output  1  sticky flag: out-of-range core access
o_err_conflict  output  1  sticky flag: core store dropped due to preload collision
o_wr_cnt  output  CNT_W  count of committed core stores, saturating

Behaviour:
- Reset (asynchronous, active-low): clears both banks, all outputs, all flags and the counter to 0 immediately. Reset asserted mid-operation aborts any pending write; no partial update.
- Word index is addr[ADDR_W-1:2]. An address is in range when its index < depth of the target bank. An address is aligned when addr[1:0] == 0.
- Instruction fetch:
  - Every cycle, o_i_inst <= ibank[index(i_i_addr)]. Latency is exactly 1 cycle.
  - If the fetch address is out of range or misaligned, o_i_inst <= 0 and the matching error flag is set. A zero word is the core's end marker.
- Data read:
  - Every cycle, o_d_rdata <= dbank[index(i_d_addr)]. Latency is 1 cycle.
  - Read-before-write: a store and a read to the same word in the same cycle return the old word. The new word is visible on the following cycle.
  - Out of range or misaligned: o_d_rdata <= 0, flag set.
- Core store (i_d_wen = 1):
  - Commits dbank[index] <= i_d_wdata on the rising edge only if the address is aligned and in range, and no conflicting preload occurs.
  - A committed store increments o_wr_cnt. The counter saturates at 2^CNT_W - 1.
  - A rejected store leaves memory and the counter unchanged and sets the relevant flag.
- Preload (i_ld_en = 1):
  - Writes i_ld_data to the selected bank at index(i_ld_addr).
  - Misaligned or out-of-range preloads are silently ignored; they set no flag.
  - Preloads do not affect o_wr_cnt.
- Collision: a preload to the data bank and a core store to the same word in the same cycle.
  - The preload wins and the core store is dropped.
  - o_err_conflict is set and o_wr_cnt is not incremented.
- Preload to the instruction bank at the address currently being fetched: o_i_inst shows the old word this cycle and the new word on the next cycle.
- Error flags are sticky; only reset clears them. Multiple flags may assert in the same cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset, preload ibank[0..2] = 0x00221820, 0x20210004, 0x00000000; drive i_i_addr 0, 4, 8 -> o_i_inst shows each word one cycle later; flags remain 0.
- Core store at addr 0x10, data 0xDEADBEEF, with a simultaneous read of 0x10 -> o_d_rdata = 0 on the next cycle, then 0xDEADBEEF; o_wr_cnt = 1.
- Store at addr 0x12 -> memory unchanged, o_err_align = 1, o_wr_cnt unchanged; a subsequent store at 0x400 (index 256 >= 64) -> o_err_range = 1.
- Preload data word 0x20 = 0x11111111 and core store 0x20 = 0x22222222 in the same cycle -> reading 0x20 returns 0x11111111; o_err_conflict = 1; o_wr_cnt unchanged.
- With CNT_W = 4, issue 20 valid stores -> o_wr_cnt stops at 15.
- Assert i_rst_n low mid-stream between edges -> all outputs, flags and the counter go to 0 asynchronously; reading 0x10 afterwards returns 0.
